// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller: FSM states,
// opcodes, ALU control codes and datapath select encodings.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_ILLEGAL  = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLL = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b111;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps opcode/funct3/funct7b5 to an ALU control
// code for R-type and I-type ALU ops, and flags funct3 values with no
// supported operation (011, 100).
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   output logic [2:0] alu_control_o,
   output logic       illegal_funct_o
);

   logic is_rtype;
   assign is_rtype = (op_i == OP_RTYPE);

   // funct3 -> ALU operation; sub exists only in the register-register form
   always_comb begin
      alu_control_o   = ALU_ADD;
      illegal_funct_o = 1'b0;
      case (funct3_i)
         3'b000:  alu_control_o = (is_rtype && funct7b5_i) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_control_o = ALU_SLL;
         3'b010:  alu_control_o = ALU_SLT;
         3'b101:  alu_control_o = ALU_SRL;
         3'b110:  alu_control_o = ALU_OR;
         3'b111:  alu_control_o = ALU_AND;
         default: illegal_funct_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM controller for a multicycle RV32I-subset datapath with a shared
// memory port. Selects are decoded from the current state; only the write
// enables look at mem_ready/zero, and all of them are held low during reset.
// Memory handshake: an access presented in FETCH, MEMREAD or MEMWRITE is held
// (address select and mem_write stable) until mem_ready=1, which completes it
// in that same cycle.
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN adds cycle_count and
// instret_count performance counters.
module multicycle_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter state_t RESET_STATE = S_FETCH
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  op,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        adr_src,
   output logic        ir_write,
   output logic        mem_write,
   output logic        reg_write,
   output logic [1:0]  result_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  imm_src,
   output logic [2:0]  alu_control,
   output logic        illegal,
   output logic [3:0]  dbg_state
`ifdef MULTICYCLE_CTRL_PERF_EN
   ,
   output logic [31:0] cycle_count,
   output logic [31:0] instret_count
`endif
);

   state_t     state_q, state_d;
   logic       illegal_q;
   logic [2:0] dec_alu;
   logic       dec_illegal;
   logic       pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw;

   alu_decoder u_alu_decoder (
      .op_i            (op),
      .funct3_i        (funct3),
      .funct7b5_i      (funct7b5),
      .alu_control_o   (dec_alu),
      .illegal_funct_o (dec_illegal)
   );

   // Next-state selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = dec_illegal ? S_ILLEGAL : S_EXECR;
               OP_ITYPE:     state_d = dec_illegal ? S_ILLEGAL : S_EXECI;
               OP_BEQ:       state_d = (funct3 == 3'b000) ? S_BEQ : S_ILLEGAL;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         S_ILLEGAL:  state_d = S_ILLEGAL;
         default:    state_d = S_ILLEGAL;
      endcase
   end

   // State register and sticky illegal flag
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RESET_STATE;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_q | (state_d == S_ILLEGAL);
      end
   end

   // Per-state datapath controls; unlisted selects stay at 0
   always_comb begin
      pc_write_raw  = 1'b0;
      ir_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      reg_write_raw = 1'b0;
      adr_src       = 1'b0;
      result_src    = RES_ALUOUT;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_RS2;
      imm_src       = IMM_I;
      alu_control   = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            alu_src_b    = SRCB_FOUR;
            result_src   = RES_ALU;
            ir_write_raw = mem_ready;
            pc_write_raw = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_src   = (op == OP_SW) ? IMM_S : IMM_I;
         end
         S_MEMREAD:  adr_src = 1'b1;
         S_MEMWB: begin
            result_src    = RES_DATA;
            reg_write_raw = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src       = 1'b1;
            mem_write_raw = 1'b1;
         end
         S_EXECR: begin
            alu_src_a   = SRCA_RS1;
            alu_src_b   = SRCB_RS2;
            alu_control = dec_alu;
         end
         S_EXECI: begin
            alu_src_a   = SRCA_RS1;
            alu_src_b   = SRCB_IMM;
            imm_src     = IMM_I;
            alu_control = dec_alu;
         end
         S_ALUWB:    reg_write_raw = 1'b1;
         S_BEQ: begin
            alu_src_a    = SRCA_RS1;
            alu_src_b    = SRCB_RS2;
            alu_control  = ALU_SUB;
            pc_write_raw = zero;
         end
         S_JAL: begin
            alu_src_a    = SRCA_OLDPC;
            alu_src_b    = SRCB_FOUR;
            pc_write_raw = 1'b1;
         end
         default: ;
      endcase
   end

   // A reset arriving mid-instruction must not let any architectural write through
   assign pc_write  = pc_write_raw  & ~reset;
   assign ir_write  = ir_write_raw  & ~reset;
   assign mem_write = mem_write_raw & ~reset;
   assign reg_write = reg_write_raw & ~reset;
   assign illegal   = illegal_q;
   assign dbg_state = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
   logic [31:0] cycle_q, instret_q;
   logic        retire;

   assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ) ||
                   ((state_q == S_MEMWRITE) && mem_ready);

   // Free-running cycle and retired-instruction counters, frozen by ILLEGAL
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q   <= 32'd0;
         instret_q <= 32'd0;
      end else begin
         if (state_q != S_ILLEGAL) cycle_q <= cycle_q + 32'd1;
         if (retire) instret_q <= instret_q + 32'd1;
      end
   end

   assign cycle_count   = cycle_q;
   assign instret_count = instret_q;
`endif

endmodule
